// File: rtl/event_id_tx.sv
// Producer side of the event-ID FIFO: per-source pending counters, round-robin pick, one ID word per event.
// Optional EVENT_TX_SW_TRIG_EN adds a lowest-priority one-entry software trigger slot.
module event_id_tx #(
   parameter int NB_SRC       = 32,
   parameter int EVT_ID_WIDTH = 8,
   parameter int CNT_WIDTH    = 2,
   parameter int ID_BASE      = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NB_SRC-1:0]       events_i,
   input  logic [NB_SRC-1:0]       mask_i,
   output logic                    event_fifo_valid_o,
   input  logic                    event_fifo_fulln_i,
   output logic [EVT_ID_WIDTH-1:0] event_fifo_data_o,
   output logic [NB_SRC-1:0]       overflow_o,
   input  logic [NB_SRC-1:0]       overflow_clr_i
`ifdef EVENT_TX_SW_TRIG_EN
   ,
   input  logic                    sw_trig_valid_i,
   input  logic [EVT_ID_WIDTH-1:0] sw_trig_id_i,
   output logic                    sw_trig_ready_o
`endif
);

   localparam int PTR_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   if (NB_SRC > 2**EVT_ID_WIDTH) begin : g_cfg_err
      $error("event_id_tx: NB_SRC exceeds the event ID space");
   end

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t                  state;
   logic [CNT_WIDTH-1:0]    cnt [NB_SRC];
   logic [PTR_W-1:0]        rr_ptr, win_idx, scan_idx, next_ptr;
   logic                    hw_found, xfer, load_ok, hw_load;
   logic [NB_SRC-1:0]       inc, dec, ovf_set;
   logic [EVT_ID_WIDTH-1:0] data_q, hw_id;

   // Rotating search: first non-zero counter at or above rr_ptr, wrapping.
   always_comb begin
      hw_found = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int i = 0; i < NB_SRC; i++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + i) % NB_SRC);
         if (!hw_found && cnt[scan_idx] != '0) begin
            hw_found = 1'b1;
            win_idx  = scan_idx;
         end
      end
   end

   assign xfer     = (state == S_FULL) & event_fifo_fulln_i;
   assign load_ok  = (state == S_EMPTY) | xfer;
   assign hw_load  = load_ok & hw_found;
   assign inc      = events_i & mask_i;
   assign next_ptr = (int'(win_idx) == NB_SRC - 1) ? '0 : win_idx + 1'b1;
   assign hw_id    = EVT_ID_WIDTH'(ID_BASE + int'(win_idx));

   always_comb begin
      dec = '0;
      if (hw_load) dec[win_idx] = 1'b1;
      for (int k = 0; k < NB_SRC; k++)
         ovf_set[k] = inc[k] & ~dec[k] & (cnt[k] == CNT_MAX);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NB_SRC; k++) cnt[k] <= '0;
         overflow_o <= '0;
      end else begin
         for (int k = 0; k < NB_SRC; k++) begin
            if (inc[k] & ~dec[k]) begin
               if (cnt[k] != CNT_MAX) cnt[k] <= cnt[k] + 1'b1;
            end else if (dec[k] & ~inc[k]) begin
               cnt[k] <= cnt[k] - 1'b1;
            end
         end
         // A new saturation event outranks a clear in the same cycle.
         overflow_o <= (overflow_o & ~overflow_clr_i) | ovf_set;
      end
   end

`ifdef EVENT_TX_SW_TRIG_EN
   logic                    sw_full;
   logic [EVT_ID_WIDTH-1:0] sw_id;
   assign sw_trig_ready_o = ~sw_full;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= S_EMPTY;
         data_q <= '0;
         rr_ptr <= '0;
`ifdef EVENT_TX_SW_TRIG_EN
         sw_full <= 1'b0;
         sw_id   <= '0;
`endif
      end else begin
         if (hw_load) begin
            data_q <= hw_id;
            rr_ptr <= next_ptr;
            state  <= S_FULL;
         end
`ifdef EVENT_TX_SW_TRIG_EN
         else if (load_ok & sw_full) begin
            data_q  <= sw_id;
            state   <= S_FULL;
            sw_full <= 1'b0;
         end
`endif
         else if (xfer) begin
            state <= S_EMPTY;
         end
`ifdef EVENT_TX_SW_TRIG_EN
         // Accept only into an empty slot, so this never collides with the slot load above.
         if (sw_trig_valid_i & ~sw_full) begin
            sw_full <= 1'b1;
            sw_id   <= sw_trig_id_i;
         end
`endif
      end
   end

   assign event_fifo_valid_o = (state == S_FULL);
   assign event_fifo_data_o  = data_q;

endmodule
